// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared constants for the FP multiplier arbiter
// Purpose: FSM state encodings and IEEE754 single-precision constants
//          used by the arbiter and its helpers.
// Ports:   none (package).
package fp_pkg;

  localparam int FP_W = 32;

  // Quiet NaN returned when the multiplier never completes.
  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC00000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority picker
// Purpose: returns the first set request bit searching upward from ptr_i+1
//          (mod N_REQ), so the last-served index becomes lowest priority.
// Ports:   req_i   - request vector
//          ptr_i   - index of the most recently granted requester
//          valid_o - at least one request is set
//          idx_o   - chosen requester index
module rr_pick
  import fp_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    // Scan from the farthest candidate back toward ptr+1 so the nearest
    // set bit is the one left standing.
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(ptr_i) + k) % N_REQ);
      if (req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// rtl/fp_mul_arbiter.sv - round-robin arbiter sharing one FP multiplier
// Purpose: serialises N_REQ requesters onto a single ready/done multiplier,
//          returning each product with a one-cycle ack; a watchdog forces a
//          quiet-NaN completion and sets a sticky err if done never arrives.
// Ports:   clk, rst           - clock, async active-high reset
//          req, req_op1/op2   - per-requester level request and operands
//          ack, res           - one-hot completion pulse and held product
//          grant_id, busy     - requester being served, not-idle flag
//          err                - sticky watchdog flag
//          mul_ready/op1/op2  - start pulse and operands to multiplier
//          mul_res, mul_done  - multiplier result and completion (pulse/level)
module fp_mul_arbiter
  import fp_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*FP_W-1:0]    req_op1,
  input  logic [N_REQ*FP_W-1:0]    req_op2,
  output logic [N_REQ-1:0]         ack,
  output logic [FP_W-1:0]          res,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     err,
  output logic                     mul_ready,
  output logic [FP_W-1:0]          mul_op1,
  output logic [FP_W-1:0]          mul_op2,
  input  logic [FP_W-1:0]          mul_res,
  input  logic                     mul_done
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [FP_W-1:0]  res_q, res_d;
  logic [FP_W-1:0]  op1_q, op1_d;
  logic [FP_W-1:0]  op2_q, op2_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    ack_d   = '0;
    res_d   = res_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    wd_d    = wd_q;
    rdy_d   = rdy_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          ptr_d   = pick_idx;
          op1_d   = req_op1[int'(pick_idx)*FP_W +: FP_W];
          op2_d   = req_op2[int'(pick_idx)*FP_W +: FP_W];
          rdy_d   = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A done still high from a previous level-held completion is
        // ignored here; WAIT only starts looking one cycle later.
        rdy_d   = 1'b0;
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Done is tested first so a completion on the expiry cycle wins.
        if (mul_done) begin
          res_d          = mul_res;
          ack_d[grant_q] = 1'b1;
          state_d        = ST_DRAIN;
        end else if (TIMEOUT != 0 && wd_q == CNT_W'(TIMEOUT - 1)) begin
          res_d          = FP_QNAN;
          ack_d[grant_q] = 1'b1;
          err_d          = 1'b1;
          state_d        = ST_DRAIN;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        // Hold here while done is still asserted so a level done cannot
        // complete a second time.
        if (!mul_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= IDX_W'(N_REQ - 1);
      grant_q <= '0;
      ack_q   <= '0;
      res_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      wd_q    <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      res_q   <= res_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      wd_q    <= wd_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign ack       = ack_q;
  assign res       = res_q;
  assign grant_id  = grant_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign mul_ready = rdy_q;
  assign mul_op1   = op1_q;
  assign mul_op2   = op2_q;

endmodule
